alu_multiword_seq: RTL and testbench

Multi-precision operation sequencer that sits directly upstream of the 16-bit arithmetic unit and also collects its results. It accepts one command of up to 64-bit operands, then drives the arithmetic unit one 16-bit slice per cycle, least-significant first. Each slice's carry_out is chained into the next slice's carry_in. It assembles the result slices and returns a single response with aggregate flags.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_multiword_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_multiword_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants and types for the multi-word ALU sequencer
package alu_seq_pkg;

    localparam int WORD_W    = 16;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SEL_PASS_A = 4'b0000;
    localparam logic [3:0] SEL_SUB    = 4'b0110;
    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_DOUBLE = 4'b1100;

endpackage

// File: rtl/alu_multiword_seq.sv
// rtl/alu_multiword_seq.sv - slices a wide command onto a 16-bit arithmetic unit and assembles the response
module alu_multiword_seq #(
    parameter int WORD_W    = alu_seq_pkg::WORD_W,
    parameter int MAX_WORDS = alu_seq_pkg::MAX_WORDS,
    parameter int CNT_W     = alu_seq_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_select,
    input  logic [CNT_W-1:0]              cmd_words,
    input  logic                          cmd_carry_in,
    input  logic [WORD_W*MAX_WORDS-1:0]   cmd_a,
    input  logic [WORD_W*MAX_WORDS-1:0]   cmd_b,
    output logic [WORD_W-1:0]             alu_a,
    output logic [WORD_W-1:0]             alu_b,
    output logic [3:0]                    alu_select,
    output logic                          alu_carry_in,
    input  logic [WORD_W-1:0]             alu_result,
    input  logic                          alu_carry_out,
    input  logic                          alu_compare,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WORD_W*MAX_WORDS-1:0]   rsp_result,
    output logic                          rsp_carry,
    output logic                          rsp_equal,
    output logic                          rsp_zero
);
    import alu_seq_pkg::*;

    localparam int DATA_W = WORD_W * MAX_WORDS;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic [3:0]          r_sel;
    logic [CNT_W-1:0]    r_words;
    logic [CNT_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_equal;

    logic                w_accept;
    logic                w_last;
    logic [WORD_W-1:0]   w_a_slice;
    logic [WORD_W-1:0]   w_b_slice;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_last   = (r_idx == r_words);

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the command-side handshake.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Select the operand slices addressed by the current index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_a_slice = r_a[i*WORD_W +: WORD_W];
                w_b_slice = r_b[i*WORD_W +: WORD_W];
            end
        end
    end

    // Latch the command on accept, then collect one result slice per RUN cycle with carry chaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_sel    <= '0;
            r_words  <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_equal  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= cmd_a;
                        r_b      <= cmd_b;
                        r_sel    <= cmd_select;
                        r_words  <= cmd_words;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_carry  <= cmd_carry_in;
                        r_equal  <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < MAX_WORDS; i++) begin
                        if (r_idx == CNT_W'(i)) begin
                            r_result[i*WORD_W +: WORD_W] <= alu_result;
                        end
                    end
                    r_carry <= alu_carry_out;
                    r_equal <= r_equal & alu_compare;
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Drive the arithmetic unit only while running and expose the response only in DONE.
    always_comb begin
        alu_a        = '0;
        alu_b        = '0;
        alu_select   = '0;
        alu_carry_in = 1'b0;
        rsp_valid    = 1'b0;
        rsp_result   = '0;
        rsp_carry    = 1'b0;
        rsp_equal    = 1'b0;
        rsp_zero     = 1'b0;
        if (r_state == RUN) begin
            alu_a        = w_a_slice;
            alu_b        = w_b_slice;
            alu_select   = r_sel;
            alu_carry_in = r_carry;
        end
        if (r_state == DONE) begin
            rsp_valid  = 1'b1;
            rsp_result = r_result;
            rsp_carry  = r_carry;
            rsp_equal  = r_equal;
            rsp_zero   = ~|r_result;
        end
    end

endmodule

// File: tb/tb_alu_multiword_seq.sv
// tb/tb_alu_multiword_seq.sv - self-checking bench for alu_multiword_seq with a slice-level arithmetic unit model
module tb_alu_multiword_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic        carry;
        logic        equal;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_select;
    logic [1:0]  cmd_words;
    logic        cmd_carry_in;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_select;
    logic        alu_carry_in;
    logic [15:0] alu_result;
    logic        alu_carry_out;
    logic        alu_compare;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_equal;
    logic        rsp_zero;

    logic [16:0] w_sum;

    exp_t        sb[$];
    exp_t        last_exp;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    alu_multiword_seq dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_select    (cmd_select),
        .cmd_words     (cmd_words),
        .cmd_carry_in  (cmd_carry_in),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_select    (alu_select),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .alu_compare   (alu_compare),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_carry     (rsp_carry),
        .rsp_equal     (rsp_equal),
        .rsp_zero      (rsp_zero)
    );

    // Combinational 16-bit arithmetic unit sitting beside the sequencer.
    always_comb begin
        w_sum = '0;
        case (alu_select)
            SEL_ADD:    w_sum = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_carry_in);
            SEL_SUB:    w_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(alu_carry_in);
            SEL_DOUBLE: w_sum = {1'b0, alu_a} + {1'b0, alu_a} + 17'(alu_carry_in);
            SEL_PASS_A: w_sum = {1'b0, alu_a};
            default:    w_sum = '0;
        endcase
    end
    assign alu_result    = w_sum[15:0];
    assign alu_carry_out = w_sum[16];
    assign alu_compare   = (alu_a == alu_b);

    // Whole-width reference: the chained slices behave as one wide operation.
    function automatic exp_t expect_of(input logic [3:0] sel, input int words, input logic cin,
                                       input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        int          nbits;
        logic [64:0] mask;
        logic [64:0] am;
        logic [64:0] bm;
        logic [64:0] full;
        nbits = (words + 1) * 16;
        mask  = (65'd1 << nbits) - 65'd1;
        am    = {1'b0, a} & mask;
        bm    = {1'b0, b} & mask;
        case (sel)
            SEL_ADD:    full = am + bm + 65'(cin);
            SEL_SUB:    full = am + ((~{1'b0, b}) & mask) + 65'(cin);
            SEL_DOUBLE: full = am + am + 65'(cin);
            SEL_PASS_A: full = am;
            default:    full = '0;
        endcase
        e.result = full[63:0] & mask[63:0];
        e.carry  = full[nbits];
        e.equal  = (am == bm);
        e.zero   = (e.result == 64'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic [3:0] sel, input logic [1:0] words, input logic cin,
                             input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        cmd_select   = sel;
        cmd_words    = words;
        cmd_carry_in = cin;
        cmd_a        = a;
        cmd_b        = b;
        cmd_valid    = 1'b1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        sb.push_back(expect_of(sel, int'(words), cin, a, b));
    endtask

    // Called at the first falling edge after the accept edge.
    task automatic await_rsp(input int words, input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(words + 1));
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
        end else begin
            last_exp = sb.pop_front();
            chk({tag, "_result"}, rsp_result, last_exp.result);
            chk({tag, "_carry"},  64'(rsp_carry), 64'(last_exp.carry));
            chk({tag, "_equal"},  64'(rsp_equal), 64'(last_exp.equal));
            chk({tag, "_zero"},   64'(rsp_zero),  64'(last_exp.zero));
        end
        chk({tag, "_cmd_ready_done"}, 64'(cmd_ready), 64'd0);
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_after_take"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_ready_after_take"}, 64'(cmd_ready), 64'd1);
    endtask

    // Safety net so a hung handshake still terminates the run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence of commands, backpressure and mid-run reset.
    initial begin
        logic        seen;
        logic [63:0] ra;
        logic [63:0] rb;

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_select   = '0;
        cmd_words    = '0;
        cmd_carry_in = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        rsp_ready    = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_cmd_ready",  64'(cmd_ready), 64'd0);
        chk("reset_rsp_valid",  64'(rsp_valid), 64'd0);
        chk("reset_rsp_result", rsp_result, 64'd0);
        chk("reset_rsp_flags",  64'({rsp_carry, rsp_equal, rsp_zero}), 64'd0);
        chk("reset_alu_a",      64'(alu_a), 64'd0);
        chk("reset_alu_select", 64'(alu_select), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

        drive_cmd(SEL_ADD, 2'd3, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1);
        await_rsp(3, "add64_cross");
        take_rsp("add64_cross");

        drive_cmd(SEL_ADD, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        await_rsp(3, "add64_ovf");
        take_rsp("add64_ovf");

        drive_cmd(SEL_PASS_A, 2'd0, 1'b0, 64'h1234, 64'h1234);
        await_rsp(0, "pass16_eq");
        take_rsp("pass16_eq");

        drive_cmd(SEL_ADD, 2'd1, 1'b1, 64'hFFFF, 64'h0);
        await_rsp(1, "add32_cin");
        take_rsp("add32_cin");

        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        drive_cmd(SEL_SUB, 2'd2, 1'b1, ra, rb);
        await_rsp(2, "sub48_rand");
        take_rsp("sub48_rand");

        ra = {$urandom, $urandom};
        drive_cmd(SEL_DOUBLE, 2'd3, 1'b1, ra, 64'h0);
        await_rsp(3, "dbl64_rand");
        take_rsp("dbl64_rand");

        drive_cmd(SEL_SUB, 2'd3, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D);
        await_rsp(3, "sub64_equal");
        take_rsp("sub64_equal");

        drive_cmd(SEL_ADD, 2'd1, 1'b0, 64'h0001_8000, 64'h0000_8000);
        await_rsp(1, "bp_first");
        cmd_select   = SEL_SUB;
        cmd_words    = 2'd0;
        cmd_carry_in = 1'b1;
        cmd_a        = 64'h10;
        cmd_b        = 64'h3;
        cmd_valid    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_valid",     64'(rsp_valid), 64'd1);
            chk("bp_hold_result",    rsp_result, last_exp.result);
            chk("bp_hold_carry",     64'(rsp_carry), 64'(last_exp.carry));
            chk("bp_hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_released_valid", 64'(rsp_valid), 64'd0);
        chk("bp_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        sb.push_back(expect_of(SEL_SUB, 0, 1'b1, 64'h10, 64'h3));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_accepted", 64'(cmd_ready), 64'd0);
        chk("bp_second_select",   64'(alu_select), 64'(SEL_SUB));
        await_rsp(0, "bp_second");
        take_rsp("bp_second");

        @(negedge clk);
        cmd_select   = SEL_ADD;
        cmd_words    = 2'd3;
        cmd_carry_in = 1'b0;
        cmd_a        = 64'h1111_2222_3333_4444;
        cmd_b        = 64'h0000_0000_0000_0001;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_slice0_a", 64'(alu_a), 64'h4444);
        @(negedge clk);
        chk("abort_slice1_a", 64'(alu_a), 64'h3333);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid",  64'(rsp_valid), 64'd0);
        chk("abort_alu_ab",     64'({alu_a, alu_b}), 64'd0);
        chk("abort_alu_ctl",    64'({alu_select, alu_carry_in}), 64'd0);
        chk("abort_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_response", 64'(seen), 64'd0);

        drive_cmd(SEL_ADD, 2'd0, 1'b0, 64'h7FFF, 64'h8001);
        await_rsp(0, "after_abort");
        take_rsp("after_abort");

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
